// File: rtl/buzzer_pkg.sv
// rtl/buzzer_pkg.sv - register map, FSM states and note record for the buzzer tone sequencer
package buzzer_pkg;

   localparam logic [1:0] ADDR_NOTE     = 2'd0;
   localparam logic [1:0] ADDR_STATUS   = 2'd1;
   localparam logic [1:0] ADDR_CONTROL  = 2'd2;
   localparam logic [1:0] ADDR_TICK_DIV = 2'd3;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_LEVEL_LSB = 4;

   localparam int CTL_ENABLE = 0;
   localparam int CTL_FLUSH  = 1;
   localparam int CTL_IRQ_EN = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      PLAY = 2'd2
   } state_t;

   // Field order matches the NOTE register layout so a write casts straight in.
   typedef struct packed {
      logic [15:0] dur;
      logic [15:0] hp;
   } note_t;

   function automatic logic [31:0] status_word(input logic busy, input logic full,
                                               input logic empty, input logic ovf,
                                               input logic [4:0] level);
      logic [31:0] w;
      w                    = '0;
      w[ST_BUSY]           = busy;
      w[ST_FULL]           = full;
      w[ST_EMPTY]          = empty;
      w[ST_OVERFLOW]       = ovf;
      w[ST_LEVEL_LSB +: 5] = level;
      return w;
   endfunction

endpackage

// File: rtl/buzzer_note_fifo.sv
// rtl/buzzer_note_fifo.sv - synchronous note queue with push/pop/flush and level reporting
module buzzer_note_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == LW'(DEPTH));
   assign empty    = (count == '0);
   assign level    = count;
   assign pop_data = mem[rd_ptr];

   // A pop frees the slot a simultaneous push needs, so full only blocks an unpaired push.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/buzzer_tone_sequencer.sv
// rtl/buzzer_tone_sequencer.sv - Avalon-MM buzzer note sequencer; BUZZER_IRQ_EN adds the queue-empty irq
module buzzer_tone_sequencer
   import buzzer_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int HP_W           = 16,
   parameter int DUR_W          = 16,
   parameter int TICK_DIV_RESET = 49999
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        out_port
`ifdef BUZZER_IRQ_EN
   ,
   output logic        irq
`endif
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int NW = HP_W + DUR_W;

   logic             wr, wr_note, wr_status, wr_ctrl, wr_div;
   logic             flush, push, pop;
   logic             fifo_full, fifo_empty;
   logic [LW-1:0]    fifo_level;
   logic [NW-1:0]    push_data, pop_data;
   note_t            push_note;
   logic [HP_W-1:0]  pop_hp;
   logic [DUR_W-1:0] pop_dur;

   logic             enable, overflow, irq_en, busy;
   logic [15:0]      tick_div, presc;
   logic             tick;

   state_t           state, state_d;
   logic             latch, stop;
   logic [HP_W-1:0]  hp_q, half_cnt;
   logic [DUR_W-1:0] dur_q;

   assign wr        = chipselect && !write_n;
   assign wr_note   = wr && (address == ADDR_NOTE);
   assign wr_status = wr && (address == ADDR_STATUS);
   assign wr_ctrl   = wr && (address == ADDR_CONTROL);
   assign wr_div    = wr && (address == ADDR_TICK_DIV);

   assign flush     = wr_ctrl && writedata[CTL_FLUSH];
   assign push      = wr_note && !flush;
   assign push_note = note_t'(writedata);
   assign push_data = {push_note.dur[DUR_W-1:0], push_note.hp[HP_W-1:0]};
   assign pop_hp    = pop_data[HP_W-1:0];
   assign pop_dur   = pop_data[NW-1:HP_W];
   assign busy      = (state != IDLE);

   buzzer_note_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (NW)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (flush),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable   <= 1'b0;
         overflow <= 1'b0;
         tick_div <= 16'(TICK_DIV_RESET);
      end else begin
         if (wr_ctrl) enable <= writedata[CTL_ENABLE];
         if (push && fifo_full && !pop) overflow <= 1'b1;
         else if (wr_status && writedata[ST_OVERFLOW]) overflow <= 1'b0;
         if (wr_div) tick_div <= writedata[15:0];
      end
   end

`ifdef BUZZER_IRQ_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en <= writedata[CTL_IRQ_EN];
         irq <= irq_en && fifo_empty && !busy && enable;
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   // Every note starts on a fresh tick boundary so its length is exactly dur*(TICK_DIV+1).
   assign tick = (presc == tick_div);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) presc <= '0;
      else if (wr_div || state == LOAD || tick) presc <= '0;
      else presc <= presc + 16'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      latch   = 1'b0;
      stop    = 1'b0;
      if (flush || (!enable && state != IDLE)) begin
         state_d = IDLE;
         stop    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (enable && !fifo_empty) state_d = LOAD;
            end
            LOAD: begin
               pop   = 1'b1;
               latch = 1'b1;
               // level counts the entry being popped, so "more left" means level >= 2.
               if (pop_dur != '0)              state_d = PLAY;
               else if (fifo_level > LW'(1))   state_d = LOAD;
               else                            state_d = IDLE;
            end
            PLAY: begin
               if (tick && dur_q == DUR_W'(1)) begin
                  stop    = 1'b1;
                  state_d = fifo_empty ? IDLE : LOAD;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= 1'b0;
         hp_q     <= '0;
         dur_q    <= '0;
         half_cnt <= '0;
      end else if (stop) begin
         out_port <= 1'b0;
      end else if (latch) begin
         hp_q     <= pop_hp;
         dur_q    <= pop_dur;
         half_cnt <= '0;
         out_port <= (pop_dur != '0) && (pop_hp != '0);
      end else if (state == PLAY) begin
         if (tick) dur_q <= dur_q - DUR_W'(1);
         if (hp_q != '0) begin
            if (half_cnt == hp_q - HP_W'(1)) begin
               half_cnt <= '0;
               out_port <= !out_port;
            end else begin
               half_cnt <= half_cnt + HP_W'(1);
            end
         end
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_STATUS:   readdata = status_word(busy, fifo_full, fifo_empty, overflow, 5'(fifo_level));
         ADDR_CONTROL: begin
            readdata[CTL_ENABLE] = enable;
            readdata[CTL_IRQ_EN] = irq_en;
         end
         ADDR_TICK_DIV: readdata[15:0] = tick_div;
         default:       readdata = '0;
      endcase
   end

endmodule
